// File: rtl/sa_pkg.sv
// Shared definitions for the systolic-array feeder: FSM encoding, the
// wavefront-count function and the tile buffer index mapping.
package sa_pkg;

  // Feeder control states; the encoding is also visible on dbg_state.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_STREAM = 2'd2,
    ST_DONE   = 2'd3
  } sa_state_t;

  // Legal systolic array dimensions.
  localparam int DIM_MIN = 2;
  localparam int DIM_MAX = 16;

  // Number of wavefronts needed to skew a DIM x DIM tile into the array.
  function automatic int wavefront_count(input int dim);
    return 2 * dim - 1;
  endfunction

  // Row-major buffer index of the element lane 'lane' needs at skew offset
  // 'step': row 'lane' for the A side, column 'lane' for the B side.
  function automatic int buf_index(input int dim, input int lane,
                                   input int step, input logic tp);
    return tp ? (step * dim + lane) : (lane * dim + step);
  endfunction

endpackage

// File: rtl/sa_tile_buf.sv
// DIM x DIM tile buffer: one synchronous write port, DIM combinational read
// ports (one per lane). Contents are not reset.
module sa_tile_buf #(
  parameter int N   = 32,
  parameter int DIM = 5,
  localparam int IW = $clog2(DIM * DIM)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [IW-1:0]     wr_addr,
  input  logic [N-1:0]      wr_data,
  input  logic [DIM*IW-1:0] rd_addr,
  output logic [DIM*N-1:0]  rd_data
);

  logic [N-1:0] mem [DIM*DIM];

  // Capture one matrix element per write strobe.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  for (genvar g = 0; g < DIM; g++) begin : g_rd
    assign rd_data[g*N +: N] = mem[rd_addr[g*IW +: IW]];
  end

endmodule

// File: rtl/param_sa_feeder.sv
// Systolic-array operand feeder. Reads a DIM x DIM tile from memory into a
// local buffer, then streams it to the array as skewed wavefronts: lane i
// is delayed by i wavefronts, carrying row i (transpose=0, A side) or
// column i (transpose=1, B side).
//
// Handshake: lane_valid/lane_data always show the current wavefront while
// streaming. The wavefront is consumed on every rising edge where
// sa_ready=1; with sa_ready=0 the outputs hold unchanged. Lanes outside
// the skew window show valid=0 and data=0 and are still part of the
// wavefront that is accepted.
module param_sa_feeder #(
  parameter int N   = 32,
  parameter int DIM = 5,   // legal range 2..16
  parameter int AW  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             init,
  input  logic [AW-1:0]    base_address,
  input  logic             transpose,
  input  logic             sa_ready,
  output logic             mem_rd_en,
  output logic [AW-1:0]    mem_addr,
  input  logic [N-1:0]     mem_rdata,
  output logic [DIM*N-1:0] lane_data,
  output logic [DIM-1:0]   lane_valid,
  output logic             busy,
  output logic             done,
  output logic [1:0]       dbg_state
);

  import sa_pkg::*;

  localparam int IW = $clog2(DIM * DIM);
  localparam int TW = $clog2(2 * DIM);
  localparam logic [IW-1:0] LAST_IDX = IW'(DIM * DIM - 1);
  localparam logic [TW-1:0] T_LAST   = TW'(wavefront_count(DIM) - 1);

  sa_state_t         state;
  logic              tp_q;
  logic [IW-1:0]     rd_cnt;
  logic [IW-1:0]     wr_idx;
  logic              rd_valid_q;
  logic [TW-1:0]     t_q;
  logic [TW-1:0]     wf_t;
  int                step;
  logic [DIM*IW-1:0] rd_addr;
  logic [DIM*N-1:0]  rd_data;
  logic [DIM*N-1:0]  wf_data;
  logic [DIM-1:0]    wf_valid;
  logic              buf_wr_en;

  assign dbg_state = state;

  // Read data returns one cycle after the strobe, so the write side is
  // driven by the delayed strobe and its own index counter.
  assign buf_wr_en = (state == ST_LOAD) && rd_valid_q;

  sa_tile_buf #(
    .N   (N),
    .DIM (DIM)
  ) u_buf (
    .clk     (clk),
    .wr_en   (buf_wr_en),
    .wr_addr (wr_idx),
    .wr_data (mem_rdata),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  // Wavefront about to be loaded into the output registers: t=0 on the
  // LOAD->STREAM edge, otherwise the successor of the current one.
  assign wf_t = (state == ST_STREAM) ? t_q + 1'b1 : '0;

  // Per-lane buffer address and validity for wavefront wf_t.
  always_comb begin
    rd_addr  = '0;
    wf_valid = '0;
    step     = 0;
    for (int i = 0; i < DIM; i++) begin
      step = int'(wf_t) - i;
      if (step >= 0 && step < DIM) begin
        wf_valid[i]         = 1'b1;
        rd_addr[i*IW +: IW] = IW'(buf_index(DIM, i, step, tp_q));
      end
    end
  end

  // Zero the data of lanes outside the skew window.
  always_comb begin
    wf_data = '0;
    for (int i = 0; i < DIM; i++) begin
      wf_data[i*N +: N] = wf_valid[i] ? rd_data[i*N +: N] : '0;
    end
  end

  // Control FSM with registered outputs. On the LOAD->STREAM edge the last
  // element is still being written, but wavefront 0 only reads element
  // [0][0], which was captured long before.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      tp_q       <= 1'b0;
      rd_cnt     <= '0;
      wr_idx     <= '0;
      rd_valid_q <= 1'b0;
      t_q        <= '0;
      mem_rd_en  <= 1'b0;
      mem_addr   <= '0;
      lane_data  <= '0;
      lane_valid <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (init) begin
            state      <= ST_LOAD;
            tp_q       <= transpose;
            mem_rd_en  <= 1'b1;
            mem_addr   <= base_address;
            rd_cnt     <= '0;
            wr_idx     <= '0;
            rd_valid_q <= 1'b0;
            busy       <= 1'b1;
          end
        end
        ST_LOAD: begin
          rd_valid_q <= mem_rd_en;
          if (mem_rd_en) begin
            if (rd_cnt == LAST_IDX) begin
              mem_rd_en <= 1'b0;
              mem_addr  <= '0;
            end else begin
              rd_cnt   <= rd_cnt + 1'b1;
              mem_addr <= mem_addr + 1'b1;
            end
          end
          if (rd_valid_q) begin
            if (wr_idx == LAST_IDX) begin
              state      <= ST_STREAM;
              wr_idx     <= '0;
              rd_cnt     <= '0;
              t_q        <= '0;
              lane_data  <= wf_data;
              lane_valid <= wf_valid;
            end else begin
              wr_idx <= wr_idx + 1'b1;
            end
          end
        end
        ST_STREAM: begin
          if (sa_ready) begin
            if (t_q == T_LAST) begin
              state      <= ST_DONE;
              t_q        <= '0;
              lane_data  <= '0;
              lane_valid <= '0;
              busy       <= 1'b0;
              done       <= 1'b1;
            end else begin
              t_q        <= t_q + 1'b1;
              lane_data  <= wf_data;
              lane_valid <= wf_valid;
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          done  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_param_sa_feeder.sv
// Directed bench for param_sa_feeder: a DIM=5 instance for the main
// sequences and a DIM=2 instance for address wrap-around.
module tb_param_sa_feeder;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOAD   = 2'd1;
  localparam logic [1:0] S_STREAM = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DIM=5 instance ----------------
  logic         init5, tp5, ready5, rd5, busy5, done5;
  logic [7:0]   base5, addr5;
  logic [31:0]  rdata5;
  logic [159:0] lane5;
  logic [4:0]   lv5;
  logic [1:0]   st5;

  param_sa_feeder #(.N(32), .DIM(5), .AW(8)) dut5 (
    .clk          (clk),
    .rst          (rst),
    .init         (init5),
    .base_address (base5),
    .transpose    (tp5),
    .sa_ready     (ready5),
    .mem_rd_en    (rd5),
    .mem_addr     (addr5),
    .mem_rdata    (rdata5),
    .lane_data    (lane5),
    .lane_valid   (lv5),
    .busy         (busy5),
    .done         (done5),
    .dbg_state    (st5)
  );

  // ---------------- DIM=2 instance ----------------
  logic        init2, tp2, ready2, rd2, busy2, done2;
  logic [7:0]  base2, addr2;
  logic [31:0] rdata2;
  logic [63:0] lane2;
  logic [1:0]  lv2;
  logic [1:0]  st2;

  param_sa_feeder #(.N(32), .DIM(2), .AW(8)) dut2 (
    .clk          (clk),
    .rst          (rst),
    .init         (init2),
    .base_address (base2),
    .transpose    (tp2),
    .sa_ready     (ready2),
    .mem_rd_en    (rd2),
    .mem_addr     (addr2),
    .mem_rdata    (rdata2),
    .lane_data    (lane2),
    .lane_valid   (lv2),
    .busy         (busy2),
    .done         (done2),
    .dbg_state    (st2)
  );

  // Memory models: mem5[a] = a, mem2[a] = 0x1000 + a, one-cycle latency.
  initial begin
    rdata5 = '0;
    rdata2 = '0;
  end
  always @(posedge clk) begin
    if (rd5) rdata5 <= {24'd0, addr5};
    if (rd2) rdata2 <= 32'h1000 + {24'd0, addr2};
  end

  // done pulse counters, sampled away from the active edge.
  int done_cnt5 = 0;
  int done_cnt2 = 0;
  always @(negedge clk) begin
    if (done5 === 1'b1) done_cnt5++;
    if (done2 === 1'b1) done_cnt2++;
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic check(input string tag, input logic [159:0] obs,
                       input logic [159:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic goto(input int c);
    while (cyc < c) tick();
  endtask

  // Pulse init for one edge; afterwards cyc=1 is the first LOAD cycle.
  task automatic start5(input logic [7:0] b, input logic tp);
    init5 = 1'b1;
    base5 = b;
    tp5   = tp;
    tick();
    init5 = 1'b0;
    cyc   = 1;
  endtask

  task automatic start2(input logic [7:0] b, input logic tp);
    init2 = 1'b1;
    base2 = b;
    tp2   = tp;
    tick();
    init2 = 1'b0;
    cyc   = 1;
  endtask

  // Watchdog: the directed sequence is a few hundred cycles long.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, n_fail=%0d", n_fail);
    $fatal(1, "timeout");
  end

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b1;
    init5 = 1'b0; tp5 = 1'b0; base5 = '0; ready5 = 1'b1;
    init2 = 1'b0; tp2 = 1'b0; base2 = '0; ready2 = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Reset state
    check("rst_busy",  busy5, 0);
    check("rst_done",  done5, 0);
    check("rst_rd_en", rd5,   0);
    check("rst_addr",  addr5, 0);
    check("rst_valid", lv5,   0);
    check("rst_data",  lane5, 0);
    check("rst_state", st5,   S_IDLE);

    // rst has priority over init on the same edge
    rst = 1'b1; init5 = 1'b1; base5 = 8'h33;
    tick();
    rst = 1'b0; init5 = 1'b0;
    check("rstpri_state", st5,   S_IDLE);
    check("rstpri_busy",  busy5, 0);
    check("rstpri_rd_en", rd5,   0);
    tick();
    check("rstpri_idle_after", st5, S_IDLE);

    // Run A: base 0, transpose 0, sa_ready high
    start5(8'h00, 1'b0);
    check("A_c1_rd_en", rd5,   1);
    check("A_c1_addr",  addr5, 8'h00);
    check("A_c1_busy",  busy5, 1);
    check("A_c1_state", st5,   S_LOAD);
    goto(25);
    check("A_c25_rd_en", rd5,   1);
    check("A_c25_addr",  addr5, 8'd24);
    goto(26);
    check("A_c26_rd_en", rd5,   0);
    check("A_c26_addr",  addr5, 0);
    check("A_c26_state", st5,   S_LOAD);
    goto(27);
    check("A_t0_state", st5,   S_STREAM);
    check("A_t0_valid", lv5,   5'b00001);
    check("A_t0_data",  lane5, 0);
    goto(31);
    check("A_t4_valid", lv5,   5'b11111);
    check("A_t4_data",  lane5, {32'd20, 32'd16, 32'd12, 32'd8, 32'd4});
    goto(35);
    check("A_t8_valid", lv5,   5'b10000);
    check("A_t8_data",  lane5, {32'd24, 128'd0});
    check("A_t8_done",  done5, 0);
    goto(36);
    check("A_c36_done",  done5, 1);
    check("A_c36_busy",  busy5, 0);
    check("A_c36_valid", lv5,   0);
    check("A_c36_state", st5,   S_DONE);
    goto(37);
    check("A_c37_done",  done5, 0);
    check("A_c37_state", st5,   S_IDLE);

    // Run B: transpose 1, with init pulses injected while streaming
    start5(8'h00, 1'b1);
    goto(31);
    check("B_t4_valid", lv5,   5'b11111);
    check("B_t4_data",  lane5, {32'd4, 32'd8, 32'd12, 32'd16, 32'd20});
    goto(32);
    init5 = 1'b1; base5 = 8'h40; tp5 = 1'b0;
    goto(34);
    init5 = 1'b0;
    goto(35);
    check("B_t8_valid", lv5,   5'b10000);
    check("B_t8_data",  lane5, {32'd24, 128'd0});
    goto(36);
    check("B_c36_done", done5, 1);
    goto(40);
    check("B_ignored_state", st5,   S_IDLE);
    check("B_ignored_busy",  busy5, 0);
    check("B_ignored_rd_en", rd5,   0);

    // Run C: sa_ready low for three cycles starting at t=2
    start5(8'h00, 1'b0);
    goto(29);
    check("C_t2_valid", lv5,   5'b00111);
    check("C_t2_data",  lane5, {64'd0, 32'd10, 32'd6, 32'd2});
    ready5 = 1'b0;
    goto(30);
    check("C_hold1_data",  lane5, {64'd0, 32'd10, 32'd6, 32'd2});
    check("C_hold1_valid", lv5,   5'b00111);
    goto(32);
    ready5 = 1'b1;
    check("C_hold3_data",  lane5, {64'd0, 32'd10, 32'd6, 32'd2});
    check("C_hold3_valid", lv5,   5'b00111);
    goto(33);
    check("C_t3_valid", lv5,   5'b01111);
    check("C_t3_data",  lane5, {32'd0, 32'd15, 32'd11, 32'd7, 32'd3});
    goto(38);
    check("C_c38_done", done5, 0);
    check("C_c38_busy", busy5, 1);
    goto(39);
    check("C_c39_done", done5, 1);
    goto(41);

    // Run D: reset during LOAD, then a clean run from base 0x10
    start5(8'h00, 1'b0);
    goto(10);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("D_abort_busy",  busy5, 0);
    check("D_abort_rd_en", rd5,   0);
    check("D_abort_addr",  addr5, 0);
    check("D_abort_state", st5,   S_IDLE);
    tick();
    start5(8'h10, 1'b0);
    check("D_c1_addr", addr5, 8'h10);
    goto(31);
    check("D_t4_valid", lv5,   5'b11111);
    check("D_t4_data",  lane5, {32'd36, 32'd32, 32'd28, 32'd24, 32'd20});
    goto(35);
    check("D_c35_done", done5, 0);
    goto(36);
    check("D_c36_done", done5, 1);
    goto(38);
    check("done5_pulses", done_cnt5, 4);

    // Run E: DIM=2, base 0xFE wraps through 0x00
    start2(8'hFE, 1'b0);
    check("E_c1_addr", addr2, 8'hFE);
    check("E_c1_rd_en", rd2, 1);
    goto(2);
    check("E_c2_addr", addr2, 8'hFF);
    goto(3);
    check("E_c3_addr", addr2, 8'h00);
    goto(4);
    check("E_c4_addr", addr2, 8'h01);
    check("E_c4_rd_en", rd2, 1);
    goto(5);
    check("E_c5_rd_en", rd2, 0);
    check("E_c5_state", st2, S_LOAD);
    goto(6);
    check("E_t0_valid", lv2,   2'b01);
    check("E_t0_data",  lane2, {32'd0, 32'h10FE});
    goto(7);
    check("E_t1_valid", lv2,   2'b11);
    check("E_t1_data",  lane2, {32'h1000, 32'h10FF});
    goto(8);
    check("E_t2_valid", lv2,   2'b10);
    check("E_t2_data",  lane2, {32'h1001, 32'd0});
    check("E_t2_done",  done2, 0);
    goto(9);
    check("E_c9_done",  done2, 1);
    check("E_c9_valid", lv2,   0);
    goto(11);
    check("done2_pulses", done_cnt2, 1);

    // ---------------- final report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
